// File: rtl/led_frame_sequencer.sv
// Walks current_led over one frame, packs each LED into a GRB word for the WS2812 serializer,
// then holds the latch gap. Define LED_SEQ_AUTO_REFRESH_EN to re-run frames continuously.
module led_frame_sequencer #(
    parameter int MAX_POS             = 16,
    parameter int FETCH_LATENCY       = 1,
    parameter int RESET_GAP_CLK_COUNT = 2500
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       update_frame,
    input  logic [7:0]                 led_green_intensity,
    input  logic [7:0]                 led_red_intensity,
    input  logic [7:0]                 led_blue_intensity,
    output logic [$clog2(MAX_POS)-1:0] current_led,
    output logic [23:0]                pixel_data,
    output logic                       pixel_valid,
    input  logic                       pixel_ready,
    output logic                       frame_busy,
    output logic                       frame_done
);

    localparam int IDX_W  = $clog2(MAX_POS);
    localparam int FCNT_W = $clog2(FETCH_LATENCY + 1);
    localparam int GCNT_W = $clog2(RESET_GAP_CLK_COUNT + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MAX_POS - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FETCH_LATENCY - 1);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(RESET_GAP_CLK_COUNT - 1);

`ifdef LED_SEQ_AUTO_REFRESH_EN
    localparam logic AUTO_REFRESH = 1'b1;
`else
    localparam logic AUTO_REFRESH = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, GAP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FCNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [GCNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                pending_q, pending_d;
    logic [23:0]         pixel_data_q, pixel_data_d;
    logic                pixel_valid_q, pixel_valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            fetch_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            pending_q     <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            fetch_cnt_q   <= fetch_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            pending_q     <= pending_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        fetch_cnt_d   = fetch_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        pending_d     = pending_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = pixel_valid_q;
        frame_done    = 1'b0;

        // Requests arriving mid-frame coalesce into a single follow-up frame.
        if (state_q != IDLE && update_frame) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                pixel_valid_d = 1'b0;
                if (update_frame) begin
                    state_d     = FETCH;
                    fetch_cnt_d = '0;
                end
            end
            FETCH: begin
                if (fetch_cnt_q == FCNT_LAST) begin
                    pixel_data_d  = {led_green_intensity, led_red_intensity, led_blue_intensity};
                    pixel_valid_d = 1'b1;
                    fetch_cnt_d   = '0;
                    state_d       = PRESENT;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                end
            end
            PRESENT: begin
                if (pixel_valid_q && pixel_ready) begin
                    pixel_valid_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        fetch_cnt_d = '0;
                        state_d     = FETCH;
                    end
                end
            end
            GAP: begin
                pixel_valid_d = 1'b0;
                if (gap_cnt_q == GCNT_LAST) begin
                    frame_done  = 1'b1;
                    gap_cnt_d   = '0;
                    fetch_cnt_d = '0;
                    // A request in this very cycle still chains straight into the next frame.
                    pending_d   = 1'b0;
                    state_d     = (AUTO_REFRESH || pending_q || update_frame) ? FETCH : IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign current_led = idx_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_busy  = (state_q != IDLE);

endmodule
